// File: rtl/aes_defs_pkg.sv
// Shared AES encipher definitions: key-length codes, round counts, FSM encoding
// and GF(2^8) helpers used by the round logic and S-box.
package aes_defs_pkg;

  localparam logic [3:0] NK_128 = 4'd3;
  localparam logic [3:0] NK_192 = 4'd5;
  localparam logic [3:0] NK_256 = 4'd7;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } enc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic nk_legal(input logic [3:0] nk);
    return (nk == NK_128) || (nk == NK_192) || (nk == NK_256);
  endfunction

  function automatic logic [3:0] nr_for_nk(input logic [3:0] nk);
    case (nk)
      NK_192:  return NR_192;
      NK_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns (skipped on the final round) and AddRoundKey.
module aes_enc_round
  import aes_defs_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_rnd,
  output logic [127:0] state_out
);

  logic [7:0] sb_in  [16];
  logic [7:0] sb_out [16];
  logic [7:0] sr     [16];
  logic [7:0] mc     [16];

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign sb_in[g] = state_in[127-8*g -: 8];
    aes_sbox u_sbox (
      .a (sb_in[g]),
      .d (sb_out[g])
    );
  end

  // Byte index is 4*column + row; row r rotates left by r columns.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sr[i] = 8'h00;
      mc[i] = 8'h00;
    end
    state_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb_out[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      state_out[127-8*i -: 8] = (final_rnd ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_defs_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] d
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] b;
    acc = 8'h00;
    b   = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ b;
      b = xtime(b);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // a^254 is the inverse for nonzero a and maps 0 to 0, as the S-box requires.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    d = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_encipher_core.sv
// Iterative AES-128/192/256 encipher: one round per clock, round keys fetched
// through a combinational address/data port from the key expansion store.
module aes_encipher_core
  import aes_defs_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int BLK_W  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        Nk,
  input  logic              key_ready,
  input  logic              start,
  input  logic [BLK_W-1:0]  block_in,
  output logic [ADDR_W-1:0] round_key_addr,
  input  logic [BLK_W-1:0]  round_key,
  output logic              busy,
  output logic              out_valid,
  output logic [BLK_W-1:0]  block_out,
  output logic              cfg_err
);

  enc_state_e       fsm;
  enc_state_e       fsm_nxt;
  logic [3:0]       round_ctr;
  logic [3:0]       nr_lat;
  logic [BLK_W-1:0] state_p0;
  logic [BLK_W-1:0] round_out;
  logic             accept;
  logic             final_rnd;

  assign accept    = (fsm == ST_IDLE) && start && key_ready && nk_legal(Nk);
  assign final_rnd = (round_ctr == nr_lat);
  assign busy      = (fsm == ST_ROUND);
  assign out_valid = (fsm == ST_DONE);

  aes_enc_round u_round (
    .state_in  (state_p0),
    .round_key (round_key),
    .final_rnd (final_rnd),
    .state_out (round_out)
  );

  always_comb begin
    fsm_nxt        = ST_IDLE;
    round_key_addr = '0;
    case (fsm)
      ST_IDLE:  fsm_nxt = accept ? ST_ROUND : ST_IDLE;
      ST_ROUND: begin
        round_key_addr = ADDR_W'(round_ctr);
        fsm_nxt        = final_rnd ? ST_DONE : ST_ROUND;
      end
      ST_DONE:  fsm_nxt = ST_IDLE;
      default:  fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= ST_IDLE;
      round_ctr <= 4'd0;
      nr_lat    <= NR_128;
      state_p0  <= '0;
      block_out <= '0;
      cfg_err   <= 1'b0;
    end else begin
      fsm     <= fsm_nxt;
      cfg_err <= (fsm == ST_IDLE) && start && key_ready && !nk_legal(Nk);
      case (fsm)
        // initial AddRoundKey with key 0; Nr frozen for the whole block
        ST_IDLE: begin
          if (accept) begin
            state_p0  <= block_in ^ round_key;
            round_ctr <= 4'd1;
            nr_lat    <= nr_for_nk(Nk);
          end
        end
        // full round per edge; the final one also loads the output register
        ST_ROUND: begin
          state_p0 <= round_out;
          if (final_rnd) begin
            block_out <= round_out;
          end else begin
            round_ctr <= round_ctr + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encipher_core.sv
// Scoreboard bench for aes_encipher_core with a table-driven AES reference model
// and a round-key memory answering the combinational key port.
module tb_aes_encipher_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   Nk;
  logic         key_ready;
  logic         start;
  logic [127:0] block_in;
  logic [3:0]   round_key_addr;
  logic [127:0] round_key;
  logic         busy;
  logic         out_valid;
  logic [127:0] block_out;
  logic         cfg_err;

  logic [127:0] rk [0:15];
  assign round_key = rk[round_key_addr];

  aes_encipher_core dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Nk             (Nk),
    .key_ready      (key_ready),
    .start          (start),
    .block_in       (block_in),
    .round_key_addr (round_key_addr),
    .round_key      (round_key),
    .busy           (busy),
    .out_valid      (out_valid),
    .block_out      (block_out),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    int           at;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] addr_log[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cfg_cnt = 0;
  int         ov_cnt = 0;
  bit         busy_seen = 0;
  logic [7:0] exp_tab [0:255];
  logic [7:0] log_tab [0:255];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_tab[(int'(log_tab[a]) + int'(log_tab[b])) % 255];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    b = (x == 8'h00) ? 8'h00 : exp_tab[(255 - int'(log_tab[x])) % 255];
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic build_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_tab[i] = 8'(x);
      log_tab[x] = 8'(i);
      x = x ^ (((x << 1) ^ (((x & 8'h80) != 0) ? 9'h11b : 9'h000)) & 8'hff);
    end
    exp_tab[255] = 8'h01;
    log_tab[0]   = 8'h00;
  endtask

  task automatic load_key(input logic [3:0] nkc, input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nw, nr;
    nw = int'(nkc) + 1;
    nr = int'(nkc) + 7;
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nw; i++) w[i] = key[255-32*i -: 32];
    for (int i = nw; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nw == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nw > 6 && i % nw == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nw] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] model_enc(input logic [3:0] nkc, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] res;
    int nr;
    nr = int'(nkc) + 7;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          s[4*c+w] = (r == nr) ? t[4*c+w] :
                     gmul(8'h02, t[4*c+w]) ^ gmul(8'h03, t[4*c+(w+1)%4]) ^
                     t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- monitor ----------------
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (cfg_err) cfg_cnt++;
      if (busy) begin
        busy_seen = 1;
        addr_log.push_back(round_key_addr);
      end
      if (out_valid) begin
        ov_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got block_out %h at cycle %0d, expected none", block_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("block_out", block_out, e.data);
          chk("out_valid_cycle", 128'(cyc), 128'(e.at));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] nkc, input logic [127:0] pt, input logic [127:0] expv);
    Nk        = nkc;
    block_in  = pt;
    key_ready = 1'b1;
    start     = 1'b1;
    exp_q.push_back('{expv, cyc + 1 + int'(nkc) + 7});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("wait_idle_timeout", 128'(n), 128'(0));
    @(negedge clk);
  endtask

  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int c0, cfg0, ov0;
    bit ok;
    logic [127:0] pt2;
    logic [3:0] nkr;
    logic [255:0] kr;

    build_tables();
    for (int r = 0; r < 16; r++) rk[r] = 128'h0;
    rst_n = 1'b0; Nk = 4'd3; key_ready = 1'b0; start = 1'b0; block_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_cfg_err", 128'(cfg_err), 128'(0));
    chk("rst_block_out", block_out, 128'h0);
    chk("rst_addr", 128'(round_key_addr), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128 with address sequence capture
    load_key(4'd3, KEY_C1);
    addr_log.delete();
    chk("idle_addr", 128'(round_key_addr), 128'(0));
    issue(4'd3, PT_C, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_idle();
    ok = (addr_log.size() == 10);
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != 4'(i + 1)) ok = 0;
    chk("addr_seq", 128'(ok), 128'(1));

    load_key(4'd5, KEY_C2);
    issue(4'd5, PT_C, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    wait_idle();
    load_key(4'd7, KEY_C3);
    issue(4'd7, PT_C, CT_C3);
    wait_idle();

    // App. B then a second start held high through the first block
    load_key(4'd3, KEY_B);
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    c0 = cyc;
    Nk = 4'd3; key_ready = 1'b1; start = 1'b1;
    block_in = 128'h3243f6a8885a308d313198a2e0370734;
    exp_q.push_back('{128'h3925841d02dc09fbdc118597196a0b32, c0 + 11});
    exp_q.push_back('{model_enc(4'd3, pt2), c0 + 23});
    @(negedge clk);
    block_in = pt2;
    while (cyc < c0 + 14) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // ignored starts and illegal Nk
    cfg0 = cfg_cnt; ov0 = ov_cnt; busy_seen = 0;
    key_ready = 1'b0; Nk = 4'd3; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("nokey_busy", 128'(busy_seen), 128'(0));
    chk("nokey_cfg_err", 128'(cfg_cnt - cfg0), 128'(0));
    chk("nokey_out_valid", 128'(ov_cnt - ov0), 128'(0));
    key_ready = 1'b1; Nk = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("badnk_cfg_err_pulses", 128'(cfg_cnt - cfg0), 128'(1));
    chk("badnk_busy", 128'(busy_seen), 128'(0));
    Nk = 4'd3;

    // reset during round 5 of AES-256
    load_key(4'd7, KEY_C3);
    issue(4'd7, PT_C, CT_C3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_block_out", block_out, 128'h0);
    chk("midrst_addr", 128'(round_key_addr), 128'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(4'd7, PT_C, CT_C3);
    wait_idle();

    // Nk changes mid-block are ignored
    issue(4'd7, PT_C, CT_C3);
    @(negedge clk);
    Nk = 4'd3;
    wait_idle();

    // random keys and plaintexts across all key sizes
    for (int n = 0; n < 6; n++) begin
      case ($urandom_range(0, 2))
        0: nkr = 4'd3;
        1: nkr = 4'd5;
        default: nkr = 4'd7;
      endcase
      kr  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt2 = {$urandom, $urandom, $urandom, $urandom};
      load_key(nkr, kr);
      issue(nkr, pt2, model_enc(nkr, pt2));
      wait_idle();
    end

    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
